// File: rtl/ti_node_fetch.sv
// Node fetch stage below the T&I unit: splits one fetch command into per-word cache
// reads and assembles the possibly out-of-order responses into one wide buffer.
module ti_node_fetch #(
    parameter int ADDR_BITS = 32,
    parameter int WORD_BITS = 32,
    parameter int MAX_WORDS = 12,
    parameter int TAG_BITS  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_BITS-1:0]           mem_addr,
    input  logic [3:0]                     mem_size,
    output logic                           ready_out,
    output logic                           valid_out,
    output logic [MAX_WORDS*WORD_BITS-1:0] mem_data,
    output logic                           req_valid,
    output logic [ADDR_BITS-1:0]           req_addr,
    output logic [TAG_BITS-1:0]            req_tag,
    input  logic                           req_ready,
    input  logic                           rsp_valid,
    input  logic [WORD_BITS-1:0]           rsp_data,
    input  logic [TAG_BITS-1:0]            rsp_tag,
    output logic                           rsp_ready
);
    // Common width for comparing tags, counts and sizes without truncation.
    localparam int CW = (TAG_BITS > 4) ? TAG_BITS + 1 : 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                         state_r;
    state_t                         nextState_s;
    logic [3:0]                     size_r;
    logic [TAG_BITS-1:0]            issueCnt_r;
    logic [ADDR_BITS-1:0]           reqAddr_r;
    logic [MAX_WORDS-1:0]           recvMask_r;
    logic [MAX_WORDS*WORD_BITS-1:0] memData_r;
    logic                           readyOut_r;
    logic                           validOut_r;
    logic                           reqValid_r;

    logic                           accept_s;
    logic                           reqFire_s;
    logic                           lastReq_s;
    logic                           rspHit_s;
    logic                           allRecv_s;
    logic [3:0]                     clampSize_s;
    logic [MAX_WORDS-1:0]           sizeMask_s;
    logic [MAX_WORDS-1:0]           rspBit_s;
    logic                           unusedAddrBits_s;

    // Byte-offset bits of the command address are discarded by design.
    assign unusedAddrBits_s = ^mem_addr[1:0];

    // Command decode, response filtering and completion detection.
    always_comb begin
        accept_s  = start && (state_r == IDLE);
        reqFire_s = reqValid_r && req_ready;
        if (CW'(mem_size) > CW'(MAX_WORDS)) begin
            clampSize_s = 4'(MAX_WORDS);
        end else begin
            clampSize_s = mem_size;
        end
        lastReq_s = (CW'(issueCnt_r) == (CW'(size_r) - CW'(1'b1)));
        rspHit_s  = rsp_valid && ((state_r == REQ) || (state_r == WAIT))
                    && (CW'(rsp_tag) < CW'(size_r));
        rspBit_s  = {MAX_WORDS{1'b0}};
        if (rspHit_s) begin
            rspBit_s[rsp_tag] = 1'b1;
        end else begin
            rspBit_s = {MAX_WORDS{1'b0}};
        end
        for (int i = 0; i < MAX_WORDS; i++) begin
            sizeMask_s[i] = (CW'(i) < CW'(size_r));
        end
        // Completion counts the word arriving this very cycle.
        allRecv_s = (((recvMask_r | rspBit_s) & sizeMask_s) == sizeMask_s);
    end

    // Next-state logic of the fetch sequencer.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    nextState_s = (clampSize_s == 4'd0) ? DONE : REQ;
                end else begin
                    nextState_s = IDLE;
                end
            end
            REQ: begin
                if (reqFire_s && lastReq_s) begin
                    nextState_s = allRecv_s ? DONE : WAIT;
                end else begin
                    nextState_s = REQ;
                end
            end
            WAIT: begin
                if (allRecv_s) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = WAIT;
                end
            end
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // State register, request bookkeeping and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            readyOut_r <= 1'b1;
            validOut_r <= 1'b0;
            reqValid_r <= 1'b0;
            size_r     <= 4'd0;
            issueCnt_r <= {TAG_BITS{1'b0}};
            reqAddr_r  <= {ADDR_BITS{1'b0}};
            recvMask_r <= {MAX_WORDS{1'b0}};
        end else begin
            state_r    <= nextState_s;
            readyOut_r <= (nextState_s == IDLE);
            validOut_r <= (nextState_s == DONE);
            reqValid_r <= (nextState_s == REQ);
            if (accept_s) begin
                size_r     <= clampSize_s;
                issueCnt_r <= {TAG_BITS{1'b0}};
                reqAddr_r  <= {mem_addr[ADDR_BITS-1:2], 2'b00};
                recvMask_r <= {MAX_WORDS{1'b0}};
            end else begin
                size_r     <= size_r;
                recvMask_r <= recvMask_r | rspBit_s;
                // The running address tracks base + 4*issueCnt.
                if (reqFire_s) begin
                    issueCnt_r <= issueCnt_r + TAG_BITS'(1'b1);
                    reqAddr_r  <= reqAddr_r + ADDR_BITS'(3'd4);
                end else begin
                    issueCnt_r <= issueCnt_r;
                    reqAddr_r  <= reqAddr_r;
                end
            end
        end
    end

    // Response word capture; the buffer is cleared on every accepted command.
    always_ff @(posedge clk) begin
        if (reset) begin
            memData_r <= {(MAX_WORDS*WORD_BITS){1'b0}};
        end else if (accept_s) begin
            memData_r <= {(MAX_WORDS*WORD_BITS){1'b0}};
        end else if (rspHit_s) begin
            memData_r[rsp_tag*WORD_BITS +: WORD_BITS] <= rsp_data;
        end else begin
            memData_r <= memData_r;
        end
    end

    assign ready_out = readyOut_r;
    assign valid_out = validOut_r;
    assign mem_data  = memData_r;
    assign req_valid = reqValid_r;
    assign req_addr  = reqAddr_r;
    assign req_tag   = issueCnt_r;
    assign rsp_ready = 1'b1;

endmodule

// File: tb/tb_ti_node_fetch.sv
// Randomized scoreboard bench for ti_node_fetch with a behavioural cache/memory model.
`timescale 1ns/1ps
module tb_ti_node_fetch;
    localparam int MW = 12;
    localparam int DW = MW * 32;

    logic          clk = 1'b0;
    logic          reset, start, req_ready, rsp_valid;
    logic [31:0]   mem_addr, rsp_data;
    logic [3:0]    mem_size, rsp_tag;
    logic          ready_out, valid_out, req_valid, rsp_ready;
    logic [DW-1:0] mem_data;
    logic [31:0]   req_addr;
    logic [3:0]    req_tag;

    ti_node_fetch dut (
        .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr), .mem_size(mem_size),
        .ready_out(ready_out), .valid_out(valid_out), .mem_data(mem_data),
        .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [3:0] tag; logic [31:0] data; } rsp_t;
    typedef struct { logic [31:0] addr; logic [3:0] tag; } req_t;
    typedef struct { logic [DW-1:0] data; int lat; int acc; } done_t;

    rsp_t        pending[$];
    req_t        expReq[$];
    done_t       expDone[$];
    logic [31:0] memModel [logic [31:0]];

    int checks = 0, passes = 0;
    int cnt = 0, hsCnt = 0, doneCnt = 0, lastDoneCycle = 0;
    bit autoRsp = 1'b1, rspRand = 1'b0;
    int fixLat = 2, readyMode = 0, expLatNext = -1;

    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endfunction

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (memModel.exists(a)) return memModel[a];
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    // Expected buffer: the memory contents of the first n words, zero above.
    function automatic logic [DW-1:0] expData(input logic [31:0] base, input int n);
        logic [DW-1:0] d = {DW{1'b0}};
        for (int i = 0; i < n; i++) d[i*32 +: 32] = memWord(base + 32'(4 * i));
        return d;
    endfunction

    function automatic void pushRsp(input int due, input int tag, input logic [31:0] data);
        rsp_t r;
        r.due = due; r.tag = 4'(tag); r.data = data;
        pending.push_back(r);
    endfunction

    always @(posedge clk) cnt <= cnt + 1;

    // Cache request acceptance pattern
    initial begin
        req_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (readyMode)
                0:       req_ready = 1'b1;
                1:       req_ready = ((cnt % 3) == 0);
                default: req_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Cache responder: one response per cycle from the due entries
    initial begin
        int pick;
        rsp_valid = 1'b0; rsp_tag = 4'd0; rsp_data = 32'd0;
        forever begin
            @(posedge clk); #1;
            rsp_valid = 1'b0;
            pick = -1;
            for (int i = 0; i < pending.size(); i++) begin
                if (pending[i].due <= cnt) begin
                    if (pick < 0) pick = i;
                    else if (rspRand && ($urandom_range(0, 1) == 1)) pick = i;
                end
            end
            if (pick >= 0) begin
                rsp_valid = 1'b1;
                rsp_tag   = pending[pick].tag;
                rsp_data  = pending[pick].data;
                pending.delete(pick);
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        req_t        e;
        done_t       d;
        bit          busy = 1'b0, haveLast = 1'b0, prevStall = 1'b0, prevValid = 1'b0;
        logic [31:0] prevAddr = 32'd0, base;
        logic [3:0]  prevTag = 4'd0;
        logic [DW-1:0] lastData = {DW{1'b0}};
        int          n;
        forever begin
            @(negedge clk);
            if (reset) begin
                expReq.delete(); expDone.delete();
                busy = 1'b0; haveLast = 1'b0; prevStall = 1'b0; prevValid = 1'b0;
            end else begin
                if (prevStall) begin
                    check("stallValid", req_valid, 1);
                    check("stallAddr", req_addr, prevAddr);
                    check("stallTag", req_tag, prevTag);
                end
                if (busy) check("readyBusy", ready_out, 0);
                else check("readyIdle", ready_out, 1);
                if (!busy && haveLast) check("holdData", mem_data, lastData);
                if (prevValid) check("pulseWidth", valid_out, 0);
                if (req_valid && req_ready) begin
                    hsCnt++;
                    if (expReq.size() == 0) begin
                        checks++;
                        $display("FAIL extraReq: got addr %0h tag %0d, required no request", req_addr, req_tag);
                    end else begin
                        e = expReq.pop_front();
                        check("reqAddr", req_addr, e.addr);
                        check("reqTag", req_tag, e.tag);
                        if (autoRsp)
                            pushRsp(cnt + ((fixLat > 0) ? fixLat : int'($urandom_range(1, 6))),
                                    int'(e.tag), memWord(e.addr));
                    end
                end
                if (valid_out) begin
                    doneCnt++;
                    lastDoneCycle = cnt;
                    busy = 1'b0;
                    if (expDone.size() == 0) begin
                        checks++;
                        haveLast = 1'b0;
                        $display("FAIL unexpectedValid: got valid_out at cycle %0d, required none", cnt);
                    end else begin
                        d = expDone.pop_front();
                        check("memData", mem_data, d.data);
                        check("allReqsIssued", expReq.size(), 0);
                        if (d.lat >= 0) check("latency", cnt - d.acc, d.lat);
                        haveLast = 1'b1;
                        lastData = d.data;
                    end
                end
                if (start && ready_out) begin
                    base = {mem_addr[31:2], 2'b00};
                    n = (mem_size > 4'd12) ? 12 : int'(mem_size);
                    for (int i = 0; i < n; i++) begin
                        e.addr = base + 32'(4 * i);
                        e.tag  = 4'(i);
                        expReq.push_back(e);
                    end
                    d.data = expData(base, n); d.lat = expLatNext; d.acc = cnt;
                    expDone.push_back(d);
                    busy = 1'b1; haveLast = 1'b0;
                end
                prevStall = req_valid && !req_ready;
                prevAddr  = req_addr;
                prevTag   = req_tag;
                prevValid = valid_out;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [31:0] a, input int sz, input int lat);
        int k = 0;
        while (!ready_out && k < 200) begin tick(); k++; end
        if (!ready_out) begin
            checks++;
            $display("FAIL readyTimeout: got ready_out 0, required 1");
        end
        expLatNext = lat;
        start = 1'b1; mem_addr = a; mem_size = 4'(sz);
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int target, input string name);
        int k = 0;
        while (doneCnt < target && k < 400) begin tick(); k++; end
        checks++;
        if (doneCnt >= target) passes++;
        else $display("FAIL %s: got done count %0d, required %0d", name, doneCnt, target);
    endtask

    task automatic waitHs(input int target, input string name);
        int k = 0;
        while (hsCnt < target && k < 400) begin tick(); k++; end
        checks++;
        if (hsCnt >= target) passes++;
        else $display("FAIL %s: got handshakes %0d, required %0d", name, hsCnt, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, h0, tag0Due, k;
        int order[12];
        logic [31:0] a;
        reset = 1'b1; start = 1'b0; mem_addr = 32'd0; mem_size = 4'd0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rstReady", ready_out, 1);
        check("rstValid", valid_out, 0);
        check("rstReqValid", req_valid, 0);
        check("rstReqAddr", req_addr, 0);
        check("rstReqTag", req_tag, 0);
        check("rstMemData", mem_data, {DW{1'b0}});
        check("rspReady", rsp_ready, 1);
        tick();

        // BVH node, in-order responses with latency 2
        for (int i = 0; i < 8; i++) memModel[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
        autoRsp = 1'b1; rspRand = 1'b0; fixLat = 2; readyMode = 0;
        d0 = doneCnt;
        issue(32'h1000, 8, 11);
        waitDone(d0 + 1, "bvhDone");

        // Triangle node, responses in reverse tag order
        autoRsp = 1'b0; h0 = hsCnt; d0 = doneCnt;
        issue(32'h2002, 12, -1);
        waitHs(h0 + 12, "revReqs");
        for (int j = 0; j < 12; j++) pushRsp(cnt + 1 + j, 11 - j, memWord(32'h2000 + 32'(4 * (11 - j))));
        tag0Due = cnt + 12;
        waitDone(d0 + 1, "revDone");
        check("revAfterTag0", lastDoneCycle, tag0Due + 1);

        // Back-pressure with out-of-order random-latency responses
        autoRsp = 1'b1; rspRand = 1'b1; fixLat = 0; readyMode = 1; d0 = doneCnt; h0 = hsCnt;
        issue($urandom, 8, -1);
        waitDone(d0 + 1, "bpDone");
        check("bpHandshakes", hsCnt - h0, 8);

        // Size 0 and size 15 (clamped)
        readyMode = 0; d0 = doneCnt; h0 = hsCnt;
        issue(32'h3000, 0, 1);
        waitDone(d0 + 1, "size0Done");
        check("size0NoReq", hsCnt - h0, 0);
        h0 = hsCnt;
        issue(32'h4000, 15, -1);
        waitDone(d0 + 2, "size15Done");
        check("size15Clamp", hsCnt - h0, 12);

        // Stray tag 13 during a size-12 fetch, shuffled responses
        autoRsp = 1'b0; h0 = hsCnt; d0 = doneCnt;
        issue(32'h5000, 12, -1);
        waitHs(h0 + 12, "strayReqs");
        for (int i = 0; i < 12; i++) order[i] = i;
        for (int i = 11; i > 0; i--) begin
            k = int'($urandom_range(0, i)); a = 32'(order[i]); order[i] = order[k]; order[k] = int'(a);
        end
        pushRsp(cnt + 1, 13, 32'hBAD0_0013);
        for (int i = 0; i < 12; i++) pushRsp(cnt + 2 + i, order[i], memWord(32'h5000 + 32'(4 * order[i])));
        waitDone(d0 + 1, "strayDone");

        // Duplicate tag: latest data wins, single completion
        h0 = hsCnt; d0 = doneCnt;
        issue(32'h6000, 4, -1);
        waitHs(h0 + 4, "dupReqs");
        pushRsp(cnt + 1, 2, 32'hDEAD_0002);
        pushRsp(cnt + 2, 0, memWord(32'h6000));
        pushRsp(cnt + 3, 2, memWord(32'h6008));
        pushRsp(cnt + 4, 1, memWord(32'h6004));
        pushRsp(cnt + 5, 3, memWord(32'h600C));
        waitDone(d0 + 1, "dupDone");
        repeat (5) tick();
        check("dupOneDone", doneCnt - d0, 1);

        // Start while busy is ignored
        h0 = hsCnt; d0 = doneCnt;
        issue(32'h7000, 8, -1);
        waitHs(h0 + 8, "busyReqs");
        pushRsp(cnt + 1, 0, memWord(32'h7000));
        pushRsp(cnt + 2, 1, memWord(32'h7004));
        repeat (3) tick();
        start = 1'b1; mem_addr = 32'h7770; mem_size = 4'd3;
        tick();
        start = 1'b0;
        for (int i = 2; i < 8; i++) pushRsp(cnt + i, i, memWord(32'h7000 + 32'(4 * i)));
        waitDone(d0 + 1, "busyDone");
        repeat (5) tick();
        check("busyHandshakes", hsCnt - h0, 8);
        check("busyOneDone", doneCnt - d0, 1);

        // Reset in WAIT with three responses outstanding
        h0 = hsCnt; d0 = doneCnt;
        issue(32'h8000, 8, -1);
        waitHs(h0 + 8, "rstReqs");
        for (int i = 0; i < 5; i++) pushRsp(cnt + 1 + i, i, memWord(32'h8000 + 32'(4 * i)));
        repeat (6) tick();
        for (int i = 5; i < 8; i++) pushRsp(cnt + i - 2, i, memWord(32'h8000 + 32'(4 * i)));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rstMidReady", ready_out, 1);
        check("rstMidValid", valid_out, 0);
        tick();
        k = 0;
        while (pending.size() != 0 && k < 50) begin tick(); k++; end
        repeat (3) tick();
        check("rstLateNoDone", doneCnt - d0, 0);
        autoRsp = 1'b1; rspRand = 1'b0; fixLat = 3;
        issue(32'h9004, 1, 5);
        waitDone(d0 + 1, "postRstDone");

        // Randomized fetches
        for (int t = 0; t < 20; t++) begin
            autoRsp = 1'b1; rspRand = 1'b1; fixLat = 0;
            readyMode = int'($urandom_range(0, 2));
            d0 = doneCnt;
            issue($urandom, int'($urandom_range(0, 15)), -1);
            waitDone(d0 + 1, "randDone");
        end
        repeat (5) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
